// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake and status/serial outputs of the UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic                 txd;

  modport master (output wr_en, wr_data, input full, busy, done, overflow, txd);
  modport slave  (input wr_en, wr_data, output full, busy, done, overflow, txd);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO.
// The line register txd and the done pulse are both registered from the
// FSM's combinational view, so they lag the state by one cycle together.
// That keeps done aligned with the last cycle of the stop bit on the line.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 869,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_fifo_if.slave bus
);
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]     TMR_LAST  = 16'(CLK_DIV-1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS-1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS-1);
  localparam logic            ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;
  logic                 r_ovf;
  state_t               r_state;
  logic [15:0]          r_tmr;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_txd;
  logic                 r_done;

  logic                 w_full, w_nonempty, w_wr, w_tick, w_pop, w_txd, w_done;
  logic [DATA_BITS-1:0] w_head;
  state_t               w_next;

  assign w_full     = (r_count == DEPTH_C);
  assign w_nonempty = (r_count != '0);
  assign w_wr       = bus.wr_en & ~w_full;
  assign w_tick     = (r_tmr == TMR_LAST);
  assign w_head     = r_mem[r_rptr];

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= bus.wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow (a full FIFO drops even on a pop)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW+1)'(1);
      if (bus.wr_en && w_full) r_ovf <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state, FIFO pop, line level and end-of-frame strobe
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_txd  = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty) begin
          w_pop  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: begin
        w_txd = 1'b0;
        if (w_tick) w_next = S_DATA;
      end
      S_DATA: begin
        w_txd = r_shift[0];
        if (w_tick && r_bit == DATA_LAST) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_txd = r_par;
        if (w_tick) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_tick && r_bit == STOP_LAST) begin
          w_done = 1'b1;
          // chain straight into the next frame when a word is waiting
          if (w_nonempty) begin
            w_pop  = 1'b1;
            w_next = S_START;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // bit timer, bit index, shift register and parity of the word in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_tick) r_tmr <= '0;
      else                             r_tmr <= r_tmr + 16'd1;
      if (w_tick) r_bit <= (w_next != r_state) ? 3'd0 : r_bit + 3'd1;
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= (^w_head) ^ ODD_PAR;
      end else if (r_state == S_DATA && w_tick) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  // registered line and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txd  <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_txd  <= w_txd;
      r_done <= w_done;
    end
  end

  assign bus.txd      = r_txd;
  assign bus.done     = r_done;
  assign bus.full     = w_full;
  assign bus.overflow = r_ovf;
  // done cycle still shows the last stop bit on the line, so stay busy through it
  assign bus.busy     = (r_state != S_IDLE) | w_nonempty | r_done;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations, scoreboard on config A.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if #(.DATA_BITS(8)) ifa();
  uart_tx_fifo_if #(.DATA_BITS(7)) ifb();
  uart_tx_fifo_if #(.DATA_BITS(8)) ifc();

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  localparam int FA = 40;   // config A frame: 4 * (1+8+1)

  // reference state for config A
  logic [7:0] exp_q[$];
  int starts_q[$];
  int frames = 0;
  int m_pend = 0;
  int m_rem = 0;
  bit m_idle = 1'b1;
  bit m_done = 1'b0;
  bit m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic get_txd(input int w);
    case (w)
      0: return ifa.txd;
      1: return ifb.txd;
      default: return ifc.txd;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      0: return ifa.done;
      1: return ifb.done;
      default: return ifc.done;
    endcase
  endfunction

  // expected line bits of a frame, bit 0 first
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input int nb, input int par, input int sb);
    logic [15:0] f;
    int n;
    logic p;
    f = '0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (par != 0) begin
      f[n] = (par == 2) ? p : ~p;
      n++;
    end
    for (int i = 0; i < sb; i++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  // capture one frame cycle by cycle; every bit must hold for cd cycles
  task automatic cap_frame(input int w, input int cd, input int nb, input bit already, input int limit,
                           output logic [15:0] bits, output bit stable, output bit dlast,
                           output bit dearly, output bit aborted, output bit tout, output int tstart);
    logic v;
    bit found;
    bits = '0; stable = 1'b1; dlast = 1'b0; dearly = 1'b0;
    aborted = 1'b0; tout = 1'b0; tstart = 0; found = already;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (get_txd(w) == 1'b0) found = 1'b1;
    end
    if (!found) begin
      tout = 1'b1;
      return;
    end
    tstart = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cd; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          return;
        end
        v = get_txd(w);
        if (c == 0) bits[b] = v;
        else if (v !== bits[b]) stable = 1'b0;
        if (b == nb-1 && c == cd-1) dlast = get_done(w);
        else if (get_done(w)) dearly = 1'b1;
      end
    end
  endtask

  // reference model for A: FIFO occupancy plus frame countdown
  initial begin
    bit acc, pop;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend = 0; m_idle = 1'b1; m_rem = 0; m_done = 1'b0; m_ovf = 1'b0;
        exp_q.delete();
      end else begin
        acc = ifa.wr_en && (m_pend < 4);
        if (ifa.wr_en && !acc) m_ovf = 1'b1;
        pop = 1'b0;
        m_done = 1'b0;
        if (m_idle) begin
          if (m_pend > 0) begin pop = 1'b1; m_idle = 1'b0; m_rem = FA; end
        end else if (m_rem == 1) begin
          m_done = 1'b1;
          if (m_pend > 0) begin pop = 1'b1; m_rem = FA; end
          else m_idle = 1'b1;
        end else begin
          m_rem--;
        end
        m_pend = m_pend + int'(acc) - int'(pop);
        if (acc) exp_q.push_back(ifa.wr_data);
      end
    end
  end

  // per-cycle status comparison for A
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("A_full", ifa.full, m_pend == 4);
        chk("A_overflow", ifa.overflow, m_ovf);
        chk("A_done", ifa.done, m_done);
        chk("A_busy", ifa.busy, !m_idle || m_pend > 0 || m_done);
      end
    end
  end

  // monitor for A: decode each frame and pop the scoreboard
  initial begin
    logic [15:0] bits;
    bit st, dl, de, ab, to;
    int ts;
    forever begin
      @(negedge clk);
      if (chk_on && !rst && ifa.txd === 1'b0) begin
        starts_q.push_back(cyc);
        cap_frame(0, 4, 10, 1'b1, 0, bits, st, dl, de, ab, to, ts);
        if (!ab) begin
          chk("A_bit_stable", st, 1);
          chk("A_stop_bit", bits[9], 1);
          chk("A_done_last", dl, 1);
          chk("A_done_early", de, 0);
          chk("A_frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("A_word", bits[8:1], exp_q.pop_front());
          frames++;
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!ifa.busy && exp_q.size() == 0) ok = 1'b1;
    end
    chk(nm, ok, 1);
  endtask

  task automatic wr_a(input logic [7:0] d);
    @(negedge clk);
    ifa.wr_en = 1'b1;
    ifa.wr_data = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcyc, f0, st;
    logic [15:0] bits;
    bit sb, dl, de, ab, to;
    int ts;

    ifa.wr_en = 1'b0; ifa.wr_data = '0;
    ifb.wr_en = 1'b0; ifb.wr_data = '0;
    ifc.wr_en = 1'b0; ifc.wr_data = '0;

    // reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_txd", ifa.txd, 1);
    chk("rst_done", ifa.done, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_full", ifa.full, 0);
    chk("rst_overflow", ifa.overflow, 0);
    chk("rst_txd_b", ifb.txd, 1);
    chk("rst_txd_c", ifc.txd, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // single word 0xA5, first-write latency
    starts_q.delete();
    @(negedge clk);
    wcyc = cyc;
    ifa.wr_en = 1'b1; ifa.wr_data = 8'hA5;
    @(negedge clk);
    ifa.wr_en = 1'b0;
    wait_idle("idle_a5");
    chk("a5_frames", starts_q.size(), 1);
    if (starts_q.size() != 0) chk("a5_latency", starts_q[0] - wcyc, 3);

    // three frames back-to-back
    starts_q.delete();
    wr_a(8'h00); wr_a(8'hFF); wr_a(8'h55);
    @(negedge clk);
    ifa.wr_en = 1'b0;
    wait_idle("idle_b2b");
    chk("b2b_frames", starts_q.size(), 3);
    if (starts_q.size() == 3) begin
      chk("b2b_gap1", starts_q[1] - starts_q[0], FA);
      chk("b2b_gap2", starts_q[2] - starts_q[1], FA);
    end

    // six writes: one dropped
    f0 = frames;
    for (int i = 0; i < 6; i++) wr_a(8'(8'h10 + i));
    @(negedge clk);
    ifa.wr_en = 1'b0;
    wait_idle("idle_ovf");
    chk("ovf_frames", frames - f0, 5);
    chk("ovf_flag", ifa.overflow, 1);

    // reset during data bit 3 with two words queued
    starts_q.delete();
    wr_a(8'h11); wr_a(8'h22); wr_a(8'h33);
    @(negedge clk);
    ifa.wr_en = 1'b0;
    for (int i = 0; i < 200 && starts_q.size() == 0; i++) @(negedge clk);
    chk("rst_mid_started", starts_q.size(), 1);
    st = (starts_q.size() != 0) ? starts_q[0] : cyc;
    for (int i = 0; i < 100 && cyc < st + 17; i++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_txd", ifa.txd, 1);
    chk("rst_mid_busy", ifa.busy, 0);
    chk("rst_mid_full", ifa.full, 0);
    chk("rst_mid_done", ifa.done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    starts_q.delete();
    f0 = frames;
    @(negedge clk);
    wcyc = cyc;
    ifa.wr_en = 1'b1; ifa.wr_data = 8'h3C;
    @(negedge clk);
    ifa.wr_en = 1'b0;
    wait_idle("idle_post_rst");
    chk("post_rst_frames", frames - f0, 1);
    if (starts_q.size() != 0) chk("post_rst_latency", starts_q[0] - wcyc, 3);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      ifa.wr_en = ($urandom_range(0, 9) == 0);
      ifa.wr_data = 8'($urandom);
    end
    @(negedge clk);
    ifa.wr_en = 1'b0;
    wait_idle("idle_random");

    // config B: 7 data bits, even parity, 2 stop bits
    @(negedge clk);
    wcyc = cyc;
    ifb.wr_en = 1'b1; ifb.wr_data = 7'h07;
    @(negedge clk);
    ifb.wr_en = 1'b0;
    cap_frame(1, 4, 11, 1'b0, 100, bits, sb, dl, de, ab, to, ts);
    chk("b_timeout", to, 0);
    chk("b_latency", ts - wcyc, 3);
    chk("b_frame", bits, mk_frame(8'h07, 7, 2, 2));
    chk("b_stable", sb, 1);
    chk("b_done_last", dl, 1);
    chk("b_done_early", de, 0);
    @(negedge clk);
    chk("b_idle_txd", ifb.txd, 1);
    chk("b_idle_busy", ifb.busy, 0);

    // config C: odd parity, 3-cycle bits
    @(negedge clk);
    ifc.wr_en = 1'b1; ifc.wr_data = 8'h07;
    @(negedge clk);
    ifc.wr_en = 1'b0;
    cap_frame(2, 3, 11, 1'b0, 100, bits, sb, dl, de, ab, to, ts);
    chk("c_timeout", to, 0);
    chk("c_parity", bits[9], 0);
    chk("c_frame", bits, mk_frame(8'h07, 8, 1, 1));
    chk("c_stable", sb, 1);
    chk("c_done_last", dl, 1);
    @(negedge clk);
    chk("c_idle_txd", ifc.txd, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 869; clock cycles per bit, legal range 2-65535.
REQ-002 SHALL have parameter DATA_BITS, default 8; data bits per frame, legal range 5-8.
REQ-003 SHALL have parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4; power of two, range 2-64.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  write strobe; one word per asserted cycle.
REQ-009 SHALL have port wr_data  input  DATA_BITS  word to transmit, LSB sent first.
REQ-010 SHALL have port full  output  1  FIFO holds FIFO_DEPTH words.
REQ-011 SHALL have port busy  output  1  a frame is in progress or the FIFO is non-empty.
REQ-012 SHALL have port done  output  1  one-cycle pulse at the end of each frame.
REQ-013 SHALL have port overflow  output  1  sticky flag; a write was dropped.
REQ-014 SHALL have port txd  output  1  serial line, registered, idles high.

Function
REQ-015 FIFO writes SHALL be accepted when wr_en=1 and full=0.
REQ-016 A write with full=1 SHALL be dropped and SHALL set overflow=1, even if a pop occurs in the same cycle.
REQ-017 full SHALL be derived from the registered occupancy count only.
REQ-018 Simultaneous write and pop with 0 < count < FIFO_DEPTH SHALL leave count unchanged and keep word order.
REQ-019 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication of words.
REQ-020 The transmit FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-021 In IDLE with the FIFO non-empty, the FSM SHALL pop one word into a shift register and enter START on the next edge.
REQ-022 If a word is written into an empty FIFO at edge E with the FSM in IDLE, txd SHALL go low after edge E+2.
REQ-023 Every bit SHALL last exactly CLK_DIV cycles, timed by a bit timer counting 0 to CLK_DIV-1 and cleared on each bit boundary.
REQ-024 START SHALL drive txd=0.
REQ-025 DATA SHALL drive wr_data bits LSB first, DATA_BITS of them.
REQ-026 PARITY SHALL be entered only when PARITY != 0.
REQ-027 The parity bit SHALL be the XOR of the data bits for even parity, and its inverse for odd parity.
REQ-028 STOP SHALL drive txd=1 for STOP_BITS bit periods.
REQ-029 The frame length SHALL be CLK_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
REQ-030 done SHALL pulse high for exactly one cycle, coincident with the last cycle of the final stop bit.
REQ-031 If the FIFO is non-empty when the final stop bit ends, the FSM SHALL pop and enter START directly, with no idle cycle between frames.
REQ-032 If the FIFO is empty when the final stop bit ends, the FSM SHALL return to IDLE with txd=1.
REQ-033 The word being shifted SHALL be held in the shift register, unaffected by later FIFO writes.
REQ-034 busy SHALL be low only when the FSM is in IDLE and the FIFO is empty.
REQ-035 Illegal FSM encodings SHALL return to IDLE on the next edge with txd=1.

Reset
REQ-036 While rst=1, outputs SHALL be forced immediately, independent of clk: txd=1, done=0, busy=0, full=0, overflow=0.
REQ-037 While rst=1, the FIFO SHALL be emptied, pointers and count zeroed, bit timer and bit index zeroed, and the FSM set to IDLE.
REQ-038 Reset asserted mid-frame SHALL abort the frame; any partially sent frame SHALL NOT be resumed.
REQ-039 The first write after reset release SHALL follow the REQ-022 latency.

Verification (CLK_DIV=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, FIFO_DEPTH=4 unless stated)
REQ-040 Write 0xA5 once -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; one done pulse at cycle 40 of the frame; busy falls after it.
REQ-041 Write 0x00, 0xFF, 0x55 on consecutive cycles -> three frames back-to-back, 120 cycles with txd never idling between frames; three done pulses 40 cycles apart.
REQ-042 Write 6 words back-to-back while in IDLE -> full asserts; exactly one word is dropped and overflow=1; five frames are transmitted in write order.
REQ-043 PARITY=2, STOP_BITS=2, DATA_BITS=7: write 0x07 -> frame 0,1,1,1,0,0,0,0,1,1,1, 44 cycles long.
REQ-044 PARITY=1 with data 0x07 -> parity bit 0.
REQ-045 Assert rst at data bit 3 of a frame while 2 words are queued -> txd=1 immediately without waiting for a clock edge; FIFO empty; no done pulse; the next write transmits normally.
